dmem_arbiter: RTL

//  Shares the single data-memory port (dmem) between two requesters: m0 = RV32I single-cycle core

---
 rtl/dmem_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Purpose : two-master arbiter in front of the single data-memory port (m0 = core load/store, m1 = loader/debug/DMA).
// Latency : grant is combinational in the request cycle; load data returns registered one cycle after the grant.
// Backpressure: a requester that loses arbitration sees mN_stall and must hold req/attributes until granted.
//
// Ports:
//   clk, reset                     rising-edge clock, asynchronous active-high reset
//   mN_req/we/mode/adrs/wdata      request from master N (N = 0, 1), held stable until mN_gnt
//   mN_gnt, mN_stall               combinational grant / stall for master N
//   mN_rvalid, mN_rdata            registered load return for master N (one-cycle valid pulse)
//   dmemAdrs/DataStore/WE/Mode     muxed access towards dmem (write is synchronous in dmem)
//   dmemDataRead                   combinational read data from dmem
//   conflict_cnt                   saturating count of cycles with both masters requesting
module dmem_arbiter #(
    parameter int PRIORITY_M0 = 1,
    parameter int MAX_BURST   = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [2:0]       m0_mode,
    input  logic [31:0]      m0_adrs,
    input  logic [31:0]      m0_wdata,
    output logic             m0_gnt,
    output logic             m0_stall,
    output logic             m0_rvalid,
    output logic [31:0]      m0_rdata,

    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [2:0]       m1_mode,
    input  logic [31:0]      m1_adrs,
    input  logic [31:0]      m1_wdata,
    output logic             m1_gnt,
    output logic             m1_stall,
    output logic             m1_rvalid,
    output logic [31:0]      m1_rdata,

    output logic [31:0]      dmemAdrs,
    output logic [31:0]      dmemDataStore,
    output logic             dmemWE,
    output logic [2:0]       dmemMode,
    input  logic [31:0]      dmemDataRead,

    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int BW = $clog2(MAX_BURST + 1);

    // last_grant: 0 = m0 served most recently, 1 = m1. Resets to m1 so the
    // first tie in round-robin mode goes to m0.
    logic             last_grant;
    logic [BW-1:0]    burst_cnt;
    logic [CNT_W-1:0] cnt_q;

    logic both_req;
    logic pick_m1;
    logic g0;
    logic g1;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        both_req = m0_req & m1_req;
        pick_m1  = 1'b0;
        if (PRIORITY_M0 != 0) begin
            // m0 normally wins; after MAX_BURST consecutive wins over a
            // waiting m1, m1 gets exactly one slot.
            pick_m1 = (burst_cnt == BW'(MAX_BURST));
        end else begin
            // Alternate: whoever did not win last time.
            pick_m1 = ~last_grant;
        end

        g0 = 1'b0;
        g1 = 1'b0;
        // Nothing is granted while reset is high, so no write can reach dmem.
        if (!reset) begin
            if (both_req) begin
                g1 = pick_m1;
                g0 = ~pick_m1;
            end else begin
                g0 = m0_req;
                g1 = m1_req;
            end
        end
    end

    assign m0_gnt   = g0;
    assign m1_gnt   = g1;
    assign m0_stall = m0_req & ~g0 & ~reset;
    assign m1_stall = m1_req & ~g1 & ~reset;

    // ------------------------------------------------------------------
    // Datapath mux: idle cycles drive zeros rather than a stale master.
    // ------------------------------------------------------------------
    always_comb begin
        dmemAdrs      = 32'h0;
        dmemDataStore = 32'h0;
        dmemWE        = 1'b0;
        dmemMode      = 3'b000;
        if (g0) begin
            dmemAdrs      = m0_adrs;
            dmemDataStore = m0_wdata;
            dmemWE        = m0_we;
            dmemMode      = m0_mode;
        end else if (g1) begin
            dmemAdrs      = m1_adrs;
            dmemDataStore = m1_wdata;
            dmemWE        = m1_we;
            dmemMode      = m1_mode;
        end
    end

    assign conflict_cnt = cnt_q;

    // ------------------------------------------------------------------
    // Arbitration state and performance counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            burst_cnt  <= '0;
            cnt_q      <= '0;
        end else begin
            if (g0) begin
                last_grant <= 1'b0;
            end else if (g1) begin
                last_grant <= 1'b1;
            end

            // Counts only m0 wins that made m1 wait; any m1 service or an
            // absent m1 request restarts the run.
            if (g1 || !m1_req) begin
                burst_cnt <= '0;
            end else if (g0 && (burst_cnt != BW'(MAX_BURST))) begin
                burst_cnt <= burst_cnt + BW'(1);
            end

            if (both_req && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return: capture dmem read data on the edge that ends a granted
    // load. rdata is only rewritten by that master's own loads.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= 32'h0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= 32'h0;
        end else begin
            m0_rvalid <= g0 & ~m0_we;
            m1_rvalid <= g1 & ~m1_we;
            if (g0 && !m0_we) begin
                m0_rdata <= dmemDataRead;
            end
            if (g1 && !m1_we) begin
                m1_rdata <= dmemDataRead;
            end
        end
    end

endmodule
